// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Merges the in-order pipeline writeback stream and the multicycle-unit
//   result stream onto the register bank's single registered write port.
//   The pipeline always wins and is never backpressured. Multicycle results
//   are buffered in a small FIFO and drain in cycles where the pipeline has
//   no effective write. A pending scoreboard tracks registers still awaiting
//   a multicycle result, for the hazard unit.
//
// Optional feature: define WB_ARB_STARVE_GUARD_EN to enable the starvation
//   guard. When the FIFO has been blocked by the pipeline for STARVE_LIMIT
//   consecutive cycles, stall_pipe is raised until one pop completes.
//   Without the macro, stall_pipe is tied to 0.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   pipe_we/pipe_addr/pipe_data       pipeline writeback (priority source)
//   mc_valid/mc_ready/mc_addr/mc_data multicycle result handshake
//   issue_valid/issue_addr            multicycle op issued (sets pending bit)
//   rb_we/rb_addr_d/rb_data_d         registered register-bank write port
//   pending_mask                      registers awaiting a multicycle result
//   fifo_count                        FIFO occupancy, 0..FIFO_DEPTH
//   stall_pipe                        pipeline hold request for forced drain
module wb_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_we,
    input  logic [3:0]       pipe_addr,
    input  logic [31:0]      pipe_data,
    input  logic             mc_valid,
    output logic             mc_ready,
    input  logic [3:0]       mc_addr,
    input  logic [31:0]      mc_data,
    input  logic             issue_valid,
    input  logic [3:0]       issue_addr,
    output logic             rb_we,
    output logic [3:0]       rb_addr_d,
    output logic [31:0]      rb_data_d,
    output logic [15:0]      pending_mask,
    output logic [CNT_W-1:0] fifo_count,
    output logic             stall_pipe
);

    logic [3:0]       fifo_addr_q [FIFO_DEPTH];
    logic [3:0]       fifo_addr_d [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rb_we_q, rb_we_d;
    logic [3:0]       rb_addr_q, rb_addr_d_n;
    logic [31:0]      rb_data_q, rb_data_d_n;
    logic [15:0]      pending_q, pending_d;

    logic        pipe_eff, fifo_full, fifo_empty, push, pop;
    logic [3:0]  head_addr;
    logic [31:0] head_data;
    logic [15:0] set_vec, clr_vec;

    // Handshake and arbitration. mc_ready looks only at the registered count,
    // so a full FIFO refuses a push even when it pops in the same cycle.
    always_comb begin
        pipe_eff   = pipe_we && (pipe_addr != 4'd0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        push       = mc_valid && !fifo_full;
        pop        = !pipe_eff && !fifo_empty;
        head_addr  = fifo_addr_q[rd_ptr_q];
        head_data  = fifo_data_q[rd_ptr_q];
    end

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = mc_addr;
            fifo_data_d[wr_ptr_q] = mc_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Output select. Idle cycles hold address/data so the bank port does
    // not toggle needlessly. An r0 entry from the FIFO is consumed silently.
    always_comb begin
        rb_we_d     = 1'b0;
        rb_addr_d_n = rb_addr_q;
        rb_data_d_n = rb_data_q;
        if (pipe_eff) begin
            rb_we_d     = 1'b1;
            rb_addr_d_n = pipe_addr;
            rb_data_d_n = pipe_data;
        end else if (pop) begin
            rb_we_d     = (head_addr != 4'd0);
            rb_addr_d_n = head_addr;
            rb_data_d_n = head_data;
        end
    end

    // Scoreboard: a new issue to the same register beats the retiring pop.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid) set_vec[issue_addr] = 1'b1;
        if (pop)         clr_vec[head_addr]  = 1'b1;
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic            stall_q, stall_d;

    // Counter saturates at the limit; stall drops once a pop is done.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop || fifo_empty)
            starve_cnt_d = '0;
        else if (pipe_eff && (starve_cnt_q != SC_W'(STARVE_LIMIT)))
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        stall_d = stall_q;
        if (stall_q) begin
            if (pop) stall_d = 1'b0;
        end else if (starve_cnt_d == SC_W'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            stall_q      <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            stall_q      <= stall_d;
        end
    end

    assign stall_pipe = stall_q;
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign stall_pipe          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rb_we_q   <= 1'b0;
            rb_addr_q <= '0;
            rb_data_q <= '0;
            pending_q <= '0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rb_we_q     <= rb_we_d;
            rb_addr_q   <= rb_addr_d_n;
            rb_data_q   <= rb_data_d_n;
            pending_q   <= pending_d;
        end
    end

    assign mc_ready     = !fifo_full;
    assign rb_we        = rb_we_q;
    assign rb_addr_d    = rb_addr_q;
    assign rb_data_d    = rb_data_q;
    assign pending_mask = pending_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=8).
// Inputs are driven on the falling edge; outputs are checked on the next
// falling edge, i.e. after the rising edge that registers them.
module tb_wb_write_arbiter;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [3:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [3:0]  mc_addr;
    logic [31:0] mc_data;
    logic        issue_valid;
    logic [3:0]  issue_addr;
    logic        rb_we;
    logic [3:0]  rb_addr_d;
    logic [31:0] rb_data_d;
    logic [15:0] pending_mask;
    logic [2:0]  fifo_count;
    logic        stall_pipe;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_addr(mc_addr), .mc_data(mc_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rb_we(rb_we), .rb_addr_d(rb_addr_d), .rb_data_d(rb_data_d),
        .pending_mask(pending_mask), .fifo_count(fifo_count), .stall_pipe(stall_pipe)
    );

    typedef struct {
        logic        pwe;
        logic [3:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [3:0]  ma;
        logic [31:0] md;
        logic        iv;
        logic [3:0]  ia;
        logic        e_we;
        logic [3:0]  e_a;
        logic [31:0] e_d;
        logic        chk_ad;
        logic [15:0] e_pend;
        logic [2:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t tbl [26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [3:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic iv, input logic [3:0] ia);
        pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
        mc_valid = mv; mc_addr = ma; mc_data = md;
        issue_valid = iv; issue_addr = ia;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t v(logic pwe, logic [3:0] pa, logic [31:0] pd,
                               logic mv, logic [3:0] ma, logic [31:0] md,
                               logic iv, logic [3:0] ia,
                               logic e_we, logic [3:0] e_a, logic [31:0] e_d, logic chk_ad,
                               logic [15:0] e_pend, logic [2:0] e_cnt, logic e_rdy);
        vec_t r;
        r.pwe = pwe; r.pa = pa; r.pd = pd; r.mv = mv; r.ma = ma; r.md = md;
        r.iv = iv; r.ia = ia; r.e_we = e_we; r.e_a = e_a; r.e_d = e_d;
        r.chk_ad = chk_ad; r.e_pend = e_pend; r.e_cnt = e_cnt; r.e_rdy = e_rdy;
        return r;
    endfunction

    initial begin
        //            pwe pa  pd            mv ma  md        iv ia    we a   d            ad pend     cnt rdy
        tbl[0]  = v(1, 5,  32'hDEADBEEF, 0, 0,  0,        0, 0,    1, 5,  32'hDEADBEEF, 1, 16'h0000, 0, 1);
        tbl[1]  = v(0, 0,  0,            0, 0,  0,        0, 0,    0, 5,  32'hDEADBEEF, 1, 16'h0000, 0, 1);
        tbl[2]  = v(1, 7,  32'h70,       0, 0,  0,        1, 3,    1, 7,  32'h70,       1, 16'h0008, 0, 1);
        tbl[3]  = v(1, 7,  32'h71,       1, 3,  32'h11,   0, 0,    1, 7,  32'h71,       1, 16'h0008, 1, 1);
        tbl[4]  = v(1, 7,  32'h72,       0, 0,  0,        0, 0,    1, 7,  32'h72,       1, 16'h0008, 1, 1);
        tbl[5]  = v(1, 7,  32'h73,       0, 0,  0,        0, 0,    1, 7,  32'h73,       1, 16'h0008, 1, 1);
        tbl[6]  = v(0, 0,  0,            0, 0,  0,        0, 0,    1, 3,  32'h11,       1, 16'h0000, 0, 1);
        tbl[7]  = v(1, 8,  32'h80,       1, 1,  32'hA1,   0, 0,    1, 8,  32'h80,       1, 16'h0000, 1, 1);
        tbl[8]  = v(1, 8,  32'h81,       1, 2,  32'hA2,   0, 0,    1, 8,  32'h81,       1, 16'h0000, 2, 1);
        tbl[9]  = v(1, 8,  32'h82,       1, 3,  32'hA3,   0, 0,    1, 8,  32'h82,       1, 16'h0000, 3, 1);
        tbl[10] = v(1, 8,  32'h83,       1, 4,  32'hA4,   0, 0,    1, 8,  32'h83,       1, 16'h0000, 4, 0);
        tbl[11] = v(1, 8,  32'h84,       1, 5,  32'hA5,   0, 0,    1, 8,  32'h84,       1, 16'h0000, 4, 0);
        tbl[12] = v(0, 0,  0,            1, 5,  32'hA5,   0, 0,    1, 1,  32'hA1,       1, 16'h0000, 3, 1);
        tbl[13] = v(0, 0,  0,            0, 0,  0,        0, 0,    1, 2,  32'hA2,       1, 16'h0000, 2, 1);
        tbl[14] = v(0, 0,  0,            0, 0,  0,        0, 0,    1, 3,  32'hA3,       1, 16'h0000, 1, 1);
        tbl[15] = v(0, 0,  0,            0, 0,  0,        0, 0,    1, 4,  32'hA4,       1, 16'h0000, 0, 1);
        tbl[16] = v(0, 0,  0,            0, 0,  0,        0, 0,    0, 4,  32'hA4,       1, 16'h0000, 0, 1);
        tbl[17] = v(1, 10, 32'hB0,       1, 9,  32'h55,   1, 9,    1, 10, 32'hB0,       1, 16'h0200, 1, 1);
        tbl[18] = v(1, 0,  32'hFFFF,     1, 0,  32'h77,   1, 0,    1, 9,  32'h55,       1, 16'h0000, 1, 1);
        tbl[19] = v(0, 0,  0,            0, 0,  0,        0, 0,    0, 0,  0,            0, 16'h0000, 0, 1);
        tbl[20] = v(1, 6,  32'h60,       1, 12, 32'hC0,   1, 12,   1, 6,  32'h60,       1, 16'h1000, 1, 1);
        tbl[21] = v(0, 0,  0,            0, 0,  0,        1, 12,   1, 12, 32'hC0,       1, 16'h1000, 0, 1);
        tbl[22] = v(0, 0,  0,            0, 0,  0,        0, 0,    0, 12, 32'hC0,       1, 16'h1000, 0, 1);
        tbl[23] = v(1, 12, 32'h99,       0, 0,  0,        0, 0,    1, 12, 32'h99,       1, 16'h1000, 0, 1);
        tbl[24] = v(0, 0,  0,            1, 13, 32'hD0,   0, 0,    0, 12, 32'h99,       1, 16'h1000, 1, 1);
        tbl[25] = v(0, 0,  0,            0, 0,  0,        0, 0,    1, 13, 32'hD0,       1, 16'h1000, 0, 1);

        // Reset held two cycles with a multicycle result offered.
        reset = 1'b1;
        drive(0, 0, 0, 1, 4'd6, 32'h66, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("reset%0d rb_we", i), 32'(rb_we), 0);
            chk($sformatf("reset%0d mc_ready", i), 32'(mc_ready), 1);
            chk($sformatf("reset%0d fifo_count", i), 32'(fifo_count), 0);
            chk($sformatf("reset%0d pending", i), 32'(pending_mask), 0);
            chk($sformatf("reset%0d stall", i), 32'(stall_pipe), 0);
        end
        reset = 1'b0;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md,
                  tbl[i].iv, tbl[i].ia);
            step();
            chk($sformatf("v%0d rb_we", i), 32'(rb_we), 32'(tbl[i].e_we));
            if (tbl[i].chk_ad) begin
                chk($sformatf("v%0d rb_addr", i), 32'(rb_addr_d), 32'(tbl[i].e_a));
                chk($sformatf("v%0d rb_data", i), rb_data_d, tbl[i].e_d);
            end
            chk($sformatf("v%0d pending", i), 32'(pending_mask), 32'(tbl[i].e_pend));
            chk($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d mc_ready", i), 32'(mc_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d stall", i), 32'(stall_pipe), 0);
        end

        // Starvation: one buffered entry, pipeline busy for 8 blocked cycles.
        drive(1, 1, 32'h100, 1, 2, 32'h22, 0, 0);
        step();
        chk("starve fill count", 32'(fifo_count), 1);
        for (int k = 1; k <= 8; k++) begin
            drive(1, 1, 32'h100 + 32'(k), 0, 0, 0, 0, 0);
            step();
            chk($sformatf("starve blk%0d stall", k), 32'(stall_pipe), 32'(GUARD && (k >= 8)));
            chk($sformatf("starve blk%0d rb_addr", k), 32'(rb_addr_d), 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("starve drain rb_we", 32'(rb_we), 1);
        chk("starve drain rb_addr", 32'(rb_addr_d), 2);
        chk("starve drain rb_data", rb_data_d, 32'h22);
        chk("starve drain stall", 32'(stall_pipe), 0);
        chk("starve drain count", 32'(fifo_count), 0);

        // Reset in the middle of operation discards entries and pending bits.
        drive(1, 1, 32'h200, 1, 5, 32'h55, 1, 5);
        step();
        chk("midrst pre count", 32'(fifo_count), 1);
        chk("midrst pre pending", 32'(pending_mask), 32'h1020);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        chk("midrst rb_we", 32'(rb_we), 0);
        chk("midrst rb_addr", 32'(rb_addr_d), 0);
        chk("midrst rb_data", rb_data_d, 0);
        chk("midrst count", 32'(fifo_count), 0);
        chk("midrst pending", 32'(pending_mask), 0);
        step();
        chk("midrst idle rb_we", 32'(rb_we), 0);
        chk("midrst idle count", 32'(fifo_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Sits in front of the register bank's single write port (addr_d/data_d/we) and merges two writeback sources into one registered write stream.
  - Source 1: the in-order pipeline WB stage. It has priority and is never backpressured.
  - Source 2: the multicycle unit (divider/long-latency loads). It uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a 16-bit pending scoreboard of destination registers with outstanding multicycle results, for the hazard unit.

Parameters:
- FIFO_DEPTH, 4, multicycle result buffer entries; power of 2, minimum 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before a forced drain (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline writeback valid
- pipe_addr  in  4  pipeline destination register
- pipe_data  in  32  pipeline result
- mc_valid  in  1  multicycle result valid
- mc_ready  out  1  FIFO can accept (= !full, registered-state based)
- mc_addr  in  4  multicycle destination register
- mc_data  in  32  multicycle result
- issue_valid  in  1  multicycle op issued this cycle
- issue_addr  in  4  destination of issued op
- rb_we  out  1  register bank write enable (registered)
- rb_addr_d  out  4  register bank write address (registered)
- rb_data_d  out  32  register bank write data (registered)
- pending_mask  out  16  bit n = 1: rN awaits a multicycle result (registered)
- fifo_count  out  3  FIFO occupancy, 0..FIFO_DEPTH (width = clog2(FIFO_DEPTH)+1)
- stall_pipe  out  1  request pipeline hold for forced drain

Behaviour:
- Reset: rb_we=0, rb_addr_d=0, rb_data_d=0, pending_mask=0, fifo_count=0, stall_pipe=0, FIFO pointers=0.
  - Reset mid-operation discards all buffered entries and pending bits.
- Effective pipeline write: pipe_we && pipe_addr!=0. Writes to r0 from either source are never emitted on rb_we.
- FIFO push: mc_valid && mc_ready.
  - mc_ready derives from the current-cycle full flag only. A same-cycle pop does not allow a push when full.
  - Accepted entries with mc_addr==0 are stored, popped normally, and emitted with rb_we=0.
- Output select each cycle, registered with 1-cycle latency:
  - Effective pipeline write present: rb_* <= pipe_*, rb_we<=1, no pop.
  - Else FIFO non-empty: pop head; rb_we<=(head.addr!=0).
  - Else: rb_we<=0, rb_addr_d and rb_data_d hold their previous values.
- pipe_we with pipe_addr==0 counts as idle, so the FIFO may drain that cycle.
- FIFO ordering is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Empty FIFO plus push: the entry is not bypassed; earliest emission is the next cycle.
- Scoreboard, next-state per bit n:
  - Set when issue_valid && issue_addr==n && n!=0.
  - Cleared when a FIFO pop for addr n is emitted.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.
  - Re-issue to an already-pending register leaves the bit at 1. The hazard unit is responsible for preventing that WAW case.
- A pipeline write to a pending register does not clear the bit.

Optional Feature:
- Macro WB_ARB_STARVE_GUARD_EN.
- Defined:
  - A starvation counter increments each cycle the FIFO is non-empty and the pipeline wins. It resets to 0 on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, stall_pipe is asserted (registered). It stays high until one pop completes, then deasserts the following cycle.
  - While stall_pipe=1, the pipeline guarantees pipe_we=0.
- Not defined: stall_pipe tied to 0, no counter logic; the FIFO drains only in idle pipeline cycles.

Test Plan:
- Reset check: hold reset 2 cycles with mc_valid=1 -> rb_we=0, mc_ready=1, fifo_count=0, pending_mask=0 throughout.
- Pipeline passthrough: pipe_we=1, addr=5, data=0xDEADBEEF at cycle t -> rb_we=1, rb_addr_d=5, rb_data_d=0xDEADBEEF at t+1.
- Priority/buffering: issue r3; push mc (3, 0x11) while pipe writes r7 for 3 cycles -> r7 written 3 times, fifo_count=1. First idle cycle -> r3=0x11 emitted, pending_mask bit 3 cleared one cycle later.
- Full/backpressure (FIFO_DEPTH=4): 4 pushes with the pipe busy -> mc_ready=0, fifo_count=4. A fifth mc_valid is not accepted. Draining yields order r1,r2,r3,r4.
- r0 handling: pipe_we=1, addr=0 with FIFO holding (9, 0x55) -> rb_we=1 for r9. mc push (0, 0x77) -> popped, rb_we=0. issue_addr=0 -> pending_mask unchanged.
- Starve guard (macro defined, STARVE_LIMIT=8): FIFO holds 1 entry, pipe_we=1 continuously -> stall_pipe=1 after 8 blocked cycles. Bench drops pipe_we -> entry emitted, stall_pipe=0 the next cycle. Macro undefined -> stall_pipe stays 0.
